// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// mstatus bit positions, interrupt cause codes and sequencer state encoding.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MS_MIE    = 3;
   localparam int MS_MPIE   = 7;
   localparam int MS_MPP_LO = 11;
   localparam int MS_MPP_HI = 12;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   localparam logic [2:0] ST_IDLE           = 3'd0;
   localparam logic [2:0] ST_SAVE_EPC       = 3'd1;
   localparam logic [2:0] ST_SAVE_CAUSE     = 3'd2;
   localparam logic [2:0] ST_SAVE_STATUS    = 3'd3;
   localparam logic [2:0] ST_RESTORE_STATUS = 3'd4;
   localparam logic [2:0] ST_REDIRECT       = 3'd5;

   typedef enum logic [2:0] {
      IDLE           = ST_IDLE,
      SAVE_EPC       = ST_SAVE_EPC,
      SAVE_CAUSE     = ST_SAVE_CAUSE,
      SAVE_STATUS    = ST_SAVE_STATUS,
      RESTORE_STATUS = ST_RESTORE_STATUS,
      REDIRECT       = ST_REDIRECT
   } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR register-file write port driven by the trap sequencer.
interface trap_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
);
   logic              csr_we;
   logic [CSR_AW-1:0] csr_waddr;
   logic [XLEN-1:0]   csr_wdata;
   logic              csr_wready;

   modport master (output csr_we, output csr_waddr, output csr_wdata, input csr_wready);
   modport slave  (input csr_we, input csr_waddr, input csr_wdata, output csr_wready);
endinterface

// File: rtl/trap_irq_arb.sv
// Interrupt arbiter: masks raw pending lines with mie and mstatus.MIE and
// picks the highest-priority cause (MEI, then MSI, then MTI).
module trap_irq_arb
   import trap_pkg::*;
(
   input  logic [2:0] pending,     // {meip, mtip, msip}
   input  logic [2:0] mie_en,      // {MEIE, MTIE, MSIE}
   input  logic       mstatus_mie,
   output logic       take,
   output logic [3:0] code
);

   logic [2:0] active;

   assign active = pending & mie_en & {3{mstatus_mie}};

   // Fixed-priority encode of the enabled pending lines.
   always_comb begin
      take = |active;
      code = 4'd0;
      if (active[2])      code = CAUSE_MEI;
      else if (active[0]) code = CAUSE_MSI;
      else if (active[1]) code = CAUSE_MTI;
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, MRET and interrupts,
// flushes the pipeline, writes mepc/mcause/mstatus in order through the CSR
// write port and redirects fetch.
//
// state          | meaning
// ---------------+------------------------------------------------------
// IDLE           | waiting for exception / MRET / eligible interrupt
// SAVE_EPC       | writing mepc with the captured PC (word aligned)
// SAVE_CAUSE     | writing mcause with {is_irq, code}
// SAVE_STATUS    | writing mstatus: MPIE<=MIE, MIE<=0, MPP<=M
// RESTORE_STATUS | writing mstatus for MRET: MIE<=MPIE, MPIE<=1, MPP<=M
// REDIRECT       | one-cycle fetch redirect (and irq_ack for interrupts)
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exc_valid,
   input  logic [3:0]        exc_code,
   input  logic [XLEN-1:0]   exc_pc,
   input  logic              mret_valid,
   input  logic              commit_valid,
   input  logic [XLEN-1:0]   irq_pc,
   input  logic              irq_msip,
   input  logic              irq_mtip,
   input  logic              irq_meip,
   input  logic [2:0]        csr_mie_en,
   input  logic [XLEN-1:0]   csr_mstatus,
   input  logic [XLEN-1:0]   csr_mtvec,
   input  logic [XLEN-1:0]   csr_mepc,
   trap_ctrl_if.master       csr,
   output logic              flush,
   output logic              busy,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              irq_ack
);

   logic [2:0]        state;
   logic              is_irq_q;
   logic              is_mret_q;
   logic [3:0]        code_q;
   logic [XLEN-1:0]   pc_q;
   logic              first_q;

   logic              arb_take;
   logic [3:0]        arb_code;
   logic              irq_take;

   logic [XLEN-1:0]   ms_trap;
   logic [XLEN-1:0]   ms_mret;
   logic [XLEN-1:0]   trap_base;
   logic [XLEN-1:0]   trap_target;

   logic              we_c;
   logic [CSR_AW-1:0] waddr_c;
   logic [XLEN-1:0]   wdata_c;

   trap_irq_arb u_arb (
      .pending     ({irq_meip, irq_mtip, irq_msip}),
      .mie_en      (csr_mie_en),
      .mstatus_mie (csr_mstatus[MS_MIE]),
      .take        (arb_take),
      .code        (arb_code)
   );

   assign irq_take = arb_take & commit_valid;

   // Capture the winning event in IDLE and step through the CSR writes,
   // holding each write until the CSR file accepts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         is_irq_q  <= 1'b0;
         is_mret_q <= 1'b0;
         code_q    <= 4'd0;
         pc_q      <= '0;
         first_q   <= 1'b0;
      end else begin
         first_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (exc_valid) begin
                  state     <= ST_SAVE_EPC;
                  first_q   <= 1'b1;
                  is_irq_q  <= 1'b0;
                  is_mret_q <= 1'b0;
                  code_q    <= exc_code;
                  pc_q      <= exc_pc;
               end else if (mret_valid) begin
                  state     <= ST_RESTORE_STATUS;
                  first_q   <= 1'b1;
                  is_irq_q  <= 1'b0;
                  is_mret_q <= 1'b1;
               end else if (irq_take) begin
                  state     <= ST_SAVE_EPC;
                  first_q   <= 1'b1;
                  is_irq_q  <= 1'b1;
                  is_mret_q <= 1'b0;
                  code_q    <= arb_code;
                  pc_q      <= irq_pc;
               end
            end
            ST_SAVE_EPC:       if (csr.csr_wready) state <= ST_SAVE_CAUSE;
            ST_SAVE_CAUSE:     if (csr.csr_wready) state <= ST_SAVE_STATUS;
            ST_SAVE_STATUS:    if (csr.csr_wready) state <= ST_REDIRECT;
            ST_RESTORE_STATUS: if (csr.csr_wready) state <= ST_REDIRECT;
            ST_REDIRECT:       state <= ST_IDLE;
            default:           state <= ST_IDLE;
         endcase
      end
   end

   // Read-modify-write images of the live mstatus for trap entry and MRET.
   always_comb begin
      ms_trap                       = csr_mstatus;
      ms_trap[MS_MPIE]              = csr_mstatus[MS_MIE];
      ms_trap[MS_MIE]               = 1'b0;
      ms_trap[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
      ms_mret                       = csr_mstatus;
      ms_mret[MS_MIE]               = csr_mstatus[MS_MPIE];
      ms_mret[MS_MPIE]              = 1'b1;
      ms_mret[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
   end

   // Vectored mode only offsets interrupts; the add wraps at XLEN bits.
   assign trap_base   = csr_mtvec & ~XLEN'(3);
   assign trap_target = (csr_mtvec[1:0] == 2'b01 && is_irq_q)
                        ? trap_base + (XLEN'(code_q) << 2) : trap_base;

   // Outputs decode straight from state so reset silences them immediately.
   always_comb begin
      we_c           = 1'b0;
      waddr_c        = '0;
      wdata_c        = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      irq_ack        = 1'b0;
      case (state)
         ST_SAVE_EPC: begin
            we_c    = 1'b1;
            waddr_c = CSR_AW'(CSR_MEPC);
            wdata_c = pc_q & ~XLEN'(3);
         end
         ST_SAVE_CAUSE: begin
            we_c    = 1'b1;
            waddr_c = CSR_AW'(CSR_MCAUSE);
            wdata_c = {is_irq_q, {(XLEN-5){1'b0}}, code_q};
         end
         ST_SAVE_STATUS: begin
            we_c    = 1'b1;
            waddr_c = CSR_AW'(CSR_MSTATUS);
            wdata_c = ms_trap;
         end
         ST_RESTORE_STATUS: begin
            we_c    = 1'b1;
            waddr_c = CSR_AW'(CSR_MSTATUS);
            wdata_c = ms_mret;
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = is_mret_q ? (csr_mepc & ~XLEN'(3)) : trap_target;
            irq_ack        = is_irq_q;
         end
         default: ;
      endcase
   end

   assign csr.csr_we    = we_c;
   assign csr.csr_waddr = waddr_c;
   assign csr.csr_wdata = wdata_c;
   assign busy          = (state != ST_IDLE);
   assign flush         = first_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, vectored interrupt, MRET,
// backpressure, arbitration, masking, and reset mid-sequence.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:0] exc_pc;
   logic        mret_valid;
   logic        commit_valid;
   logic [31:0] irq_pc;
   logic        irq_msip, irq_mtip, irq_meip;
   logic [2:0]  csr_mie_en;
   logic [31:0] csr_mstatus, csr_mtvec, csr_mepc;
   logic        flush, busy, redirect_valid, irq_ack;
   logic [31:0] redirect_pc;

   int n_total = 0;
   int n_pass  = 0;

   trap_ctrl_if #(.XLEN(32), .CSR_AW(12)) csr_bus ();

   trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .exc_valid      (exc_valid),
      .exc_code       (exc_code),
      .exc_pc         (exc_pc),
      .mret_valid     (mret_valid),
      .commit_valid   (commit_valid),
      .irq_pc         (irq_pc),
      .irq_msip       (irq_msip),
      .irq_mtip       (irq_mtip),
      .irq_meip       (irq_meip),
      .csr_mie_en     (csr_mie_en),
      .csr_mstatus    (csr_mstatus),
      .csr_mtvec      (csr_mtvec),
      .csr_mepc       (csr_mepc),
      .csr            (csr_bus),
      .flush          (flush),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .irq_ack        (irq_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, want summary");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      exc_valid          = 1'b0;
      exc_code           = 4'd0;
      exc_pc             = 32'h0;
      mret_valid         = 1'b0;
      commit_valid       = 1'b0;
      irq_pc             = 32'h0;
      irq_msip           = 1'b0;
      irq_mtip           = 1'b0;
      irq_meip           = 1'b0;
      csr_mie_en         = 3'b000;
      csr_mstatus        = 32'h0;
      csr_mtvec          = 32'h0;
      csr_mepc           = 32'h0;
      csr_bus.csr_wready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #3;
      n_total++;
      if ({flush, busy, redirect_valid, irq_ack, csr_bus.csr_we, csr_bus.csr_waddr,
           csr_bus.csr_wdata, redirect_pc} !== 81'h0)
         $display("FAIL reset_outputs: got flush=%0b busy=%0b rv=%0b ack=%0b we=%0b addr=%h data=%h rpc=%h, want all 0",
                  flush, busy, redirect_valid, irq_ack, csr_bus.csr_we, csr_bus.csr_waddr,
                  csr_bus.csr_wdata, redirect_pc);
      else n_pass++;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({busy, flush, csr_bus.csr_we} !== 3'b000)
         $display("FAIL reset_release_idle: got busy=%0b flush=%0b we=%0b, want 0 0 0", busy, flush, csr_bus.csr_we);
      else n_pass++;
   endtask

   task automatic test_exception();
      logic [11:0] ea [3] = '{12'h341, 12'h342, 12'h300};
      logic [31:0] ed [3] = '{32'h80000010, 32'h00000002, 32'h00001880};
      tick();
      exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h80000010;
      csr_mtvec = 32'h80000100; csr_mstatus = 32'h8;
      tick();
      exc_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush, busy, redirect_valid}
             !== {1'b1, ea[i], ed[i], (i == 0), 1'b1, 1'b0})
            $display("FAIL exc_write%0d: got we=%0b addr=%h data=%h flush=%0b busy=%0b rv=%0b, want we=1 addr=%h data=%h flush=%0b",
                     i, csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush, busy, redirect_valid,
                     ea[i], ed[i], (i == 0));
         else n_pass++;
         tick();
      end
      @(negedge clk);
      n_total++;
      if ({redirect_valid, redirect_pc, irq_ack, csr_bus.csr_we, flush} !== {1'b1, 32'h80000100, 3'b000})
         $display("FAIL exc_redirect: got rv=%0b pc=%h ack=%0b we=%0b, want rv=1 pc=80000100 ack=0 we=0",
                  redirect_valid, redirect_pc, irq_ack, csr_bus.csr_we);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({redirect_valid, busy} !== 2'b00)
         $display("FAIL exc_idle: got rv=%0b busy=%0b, want 0 0", redirect_valid, busy);
      else n_pass++;
   endtask

   task automatic test_vectored_irq();
      logic [11:0] ea [3] = '{12'h341, 12'h342, 12'h300};
      logic [31:0] ed [3] = '{32'h80000044, 32'h8000000B, 32'h00001880};
      int ack_cnt = 0;
      tick();
      csr_mtvec = 32'h80000101; irq_meip = 1'b1; csr_mie_en = 3'b100;
      csr_mstatus = 32'h8; commit_valid = 1'b1; irq_pc = 32'h80000044;
      tick();
      irq_meip = 1'b0; commit_valid = 1'b0; csr_mie_en = 3'b000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ack_cnt += int'(irq_ack);
         n_total++;
         if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush}
             !== {1'b1, ea[i], ed[i], (i == 0)})
            $display("FAIL irq_write%0d: got we=%0b addr=%h data=%h flush=%0b, want we=1 addr=%h data=%h flush=%0b",
                     i, csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush, ea[i], ed[i], (i == 0));
         else n_pass++;
         tick();
      end
      @(negedge clk);
      ack_cnt += int'(irq_ack);
      n_total++;
      if ({redirect_valid, redirect_pc, irq_ack} !== {1'b1, 32'h8000012C, 1'b1})
         $display("FAIL irq_redirect: got rv=%0b pc=%h ack=%0b, want rv=1 pc=8000012c ack=1",
                  redirect_valid, redirect_pc, irq_ack);
      else n_pass++;
      tick();
      @(negedge clk);
      ack_cnt += int'(irq_ack);
      n_total++;
      if (ack_cnt !== 1)
         $display("FAIL irq_ack_pulses: got %0d, want 1", ack_cnt);
      else n_pass++;
   endtask

   task automatic test_mret();
      tick();
      mret_valid = 1'b1; csr_mstatus = 32'h1880; csr_mepc = 32'h80000016;
      tick();
      mret_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush, busy}
          !== {1'b1, 12'h300, 32'h00001888, 2'b11})
         $display("FAIL mret_write: got we=%0b addr=%h data=%h flush=%0b busy=%0b, want 1 300 00001888 1 1",
                  csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush, busy);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({redirect_valid, redirect_pc, irq_ack, csr_bus.csr_we} !== {1'b1, 32'h80000014, 2'b00})
         $display("FAIL mret_redirect: got rv=%0b pc=%h ack=%0b we=%0b, want rv=1 pc=80000014 ack=0 we=0",
                  redirect_valid, redirect_pc, irq_ack, csr_bus.csr_we);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({redirect_valid, busy} !== 2'b00)
         $display("FAIL mret_idle: got rv=%0b busy=%0b, want 0 0", redirect_valid, busy);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      tick();
      exc_valid = 1'b1; exc_code = 4'd6; exc_pc = 32'h80000200;
      csr_mtvec = 32'h80000100; csr_mstatus = 32'h0;
      tick();
      exc_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata} !== {1'b1, 12'h341, 32'h80000200})
         $display("FAIL bp_epc: got we=%0b addr=%h data=%h, want 1 341 80000200",
                  csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata);
      else n_pass++;
      tick();
      csr_bus.csr_wready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_total++;
         if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, busy, redirect_valid}
             !== {1'b1, 12'h342, 32'h00000006, 1'b1, 1'b0})
            $display("FAIL bp_cause_hold%0d: got we=%0b addr=%h data=%h busy=%0b rv=%0b, want 1 342 00000006 1 0",
                     i, csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, busy, redirect_valid);
         else n_pass++;
         tick();
         if (i == 2) csr_bus.csr_wready = 1'b1;
      end
      @(negedge clk);
      n_total++;
      if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata} !== {1'b1, 12'h300, 32'h00001800})
         $display("FAIL bp_status: got we=%0b addr=%h data=%h, want 1 300 00001800",
                  csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 32'h80000100})
         $display("FAIL bp_redirect: got rv=%0b pc=%h, want rv=1 pc=80000100", redirect_valid, redirect_pc);
      else n_pass++;
      tick();
   endtask

   task automatic test_exc_vs_irq();
      logic [11:0] ea [3] = '{12'h341, 12'h342, 12'h300};
      logic [31:0] ed [3] = '{32'h80000300, 32'h00000004, 32'h00001880};
      tick();
      exc_valid = 1'b1; exc_code = 4'd4; exc_pc = 32'h80000300;
      irq_meip = 1'b1; csr_mie_en = 3'b100; csr_mstatus = 32'h8; commit_valid = 1'b1;
      irq_pc = 32'h80000400; csr_mtvec = 32'h80000101;
      tick();
      exc_valid = 1'b0; irq_meip = 1'b0; csr_mie_en = 3'b000; commit_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata} !== {1'b1, ea[i], ed[i]})
            $display("FAIL excirq_write%0d: got we=%0b addr=%h data=%h, want we=1 addr=%h data=%h",
                     i, csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, ea[i], ed[i]);
         else n_pass++;
         tick();
      end
      @(negedge clk);
      n_total++;
      if ({redirect_valid, redirect_pc, irq_ack} !== {1'b1, 32'h80000100, 1'b0})
         $display("FAIL excirq_redirect: got rv=%0b pc=%h ack=%0b, want rv=1 pc=80000100 ack=0",
                  redirect_valid, redirect_pc, irq_ack);
      else n_pass++;
      tick();
   endtask

   task automatic test_irq_priority();
      tick();
      irq_msip = 1'b1; irq_mtip = 1'b1; csr_mie_en = 3'b011; csr_mstatus = 32'h8;
      commit_valid = 1'b1; irq_pc = 32'h80000080; csr_mtvec = 32'hFFFFFFF9;
      tick();
      irq_msip = 1'b0; irq_mtip = 1'b0; csr_mie_en = 3'b000; commit_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({csr_bus.csr_waddr, csr_bus.csr_wdata} !== {12'h341, 32'h80000080})
         $display("FAIL prio_epc: got addr=%h data=%h, want 341 80000080", csr_bus.csr_waddr, csr_bus.csr_wdata);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({csr_bus.csr_waddr, csr_bus.csr_wdata} !== {12'h342, 32'h80000003})
         $display("FAIL prio_cause: got addr=%h data=%h, want 342 80000003", csr_bus.csr_waddr, csr_bus.csr_wdata);
      else n_pass++;
      tick();
      tick();
      @(negedge clk);
      n_total++;
      if ({redirect_valid, redirect_pc, irq_ack} !== {1'b1, 32'h00000004, 1'b1})
         $display("FAIL prio_wrap_redirect: got rv=%0b pc=%h ack=%0b, want rv=1 pc=00000004 ack=1",
                  redirect_valid, redirect_pc, irq_ack);
      else n_pass++;
      tick();
   endtask

   task automatic test_irq_masked();
      logic [31:0] ms [3] = '{32'h0, 32'h8, 32'h8};
      logic        cv [3] = '{1'b1, 1'b0, 1'b1};
      logic [2:0]  en [3] = '{3'b111, 3'b111, 3'b000};
      for (int c = 0; c < 3; c++) begin
         tick();
         irq_msip = 1'b1; irq_mtip = 1'b1; irq_meip = 1'b1;
         csr_mstatus = ms[c]; commit_valid = cv[c]; csr_mie_en = en[c];
         for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_total++;
            if ({flush, csr_bus.csr_we, busy} !== 3'b000)
               $display("FAIL masked%0d_cyc%0d: got flush=%0b we=%0b busy=%0b, want 0 0 0",
                        c, k, flush, csr_bus.csr_we, busy);
            else n_pass++;
         end
      end
      tick();
      irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
      csr_mstatus = 32'h0; commit_valid = 1'b0; csr_mie_en = 3'b000;
   endtask

   task automatic test_reset_mid();
      logic [11:0] ea [3] = '{12'h341, 12'h342, 12'h300};
      logic [31:0] ed [3] = '{32'h80000600, 32'h00000005, 32'h00001880};
      tick();
      exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'h80000500;
      csr_mtvec = 32'h80000100; csr_mstatus = 32'h8;
      tick();
      exc_valid = 1'b0;
      tick();
      @(negedge clk);
      n_total++;
      if ({csr_bus.csr_we, csr_bus.csr_waddr} !== {1'b1, 12'h342})
         $display("FAIL rstmid_in_cause: got we=%0b addr=%h, want 1 342", csr_bus.csr_we, csr_bus.csr_waddr);
      else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_total++;
      if ({flush, busy, redirect_valid, irq_ack, csr_bus.csr_we, csr_bus.csr_waddr,
           csr_bus.csr_wdata, redirect_pc} !== 81'h0)
         $display("FAIL rstmid_outputs: got busy=%0b we=%0b addr=%h data=%h rv=%0b, want all 0",
                  busy, csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, redirect_valid);
      else n_pass++;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_total++;
         if ({redirect_valid, busy} !== 2'b00)
            $display("FAIL rstmid_no_redirect%0d: got rv=%0b busy=%0b, want 0 0", k, redirect_valid, busy);
         else n_pass++;
         tick();
      end
      exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h80000600;
      tick();
      exc_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush} !== {1'b1, ea[i], ed[i], (i == 0)})
            $display("FAIL rstmid_after_write%0d: got we=%0b addr=%h data=%h flush=%0b, want we=1 addr=%h data=%h flush=%0b",
                     i, csr_bus.csr_we, csr_bus.csr_waddr, csr_bus.csr_wdata, flush, ea[i], ed[i], (i == 0));
         else n_pass++;
         tick();
      end
      @(negedge clk);
      n_total++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 32'h80000100})
         $display("FAIL rstmid_after_redirect: got rv=%0b pc=%h, want rv=1 pc=80000100", redirect_valid, redirect_pc);
      else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_exception();
      test_vectored_irq();
      test_mret();
      test_backpressure();
      test_exc_vs_irq();
      test_irq_priority();
      test_irq_masked();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer that sits directly upstream of the CSR register file on its write port. It accepts synchronous exceptions and MRET from the commit stage, and pending interrupts from the CSR/interrupt lines. It arbitrates among them, flushes the pipeline, and performs ordered read-modify-write updates of mepc, mcause and mstatus. It then redirects fetch to the trap vector, or to mepc for MRET.

Parameters:
XLEN, 32, data/address width of PC and CSR data
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
exc_valid  in  1  synchronous exception at commit
exc_code  in  4  exception cause code
exc_pc  in  XLEN  PC of the faulting instruction
mret_valid  in  1  MRET at commit
commit_valid  in  1  valid instruction at commit; interrupts may only be taken when this is high
irq_pc  in  XLEN  PC of the instruction at commit (saved to mepc on interrupt)
irq_msip, irq_mtip, irq_meip  in  1 each  raw pending lines
csr_mie_en  in  3  {MEIE, MTIE, MSIE} from the mie CSR
csr_mstatus  in  XLEN  live mstatus value
csr_mtvec  in  XLEN  live mtvec value
csr_mepc  in  XLEN  live mepc value
csr_we  out  1  CSR write request
csr_waddr  out  CSR_AW  CSR write address
csr_wdata  out  XLEN  CSR write data
csr_wready  in  1  CSR file accepted the write this cycle
flush  out  1  one-cycle pipeline flush pulse
busy  out  1  sequencer active
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  XLEN  fetch target
irq_ack  out  1  one-cycle acknowledge for a taken interrupt

Behaviour:
- Reset: state IDLE; flush, busy, redirect_valid, irq_ack and csr_we all 0; csr_waddr, csr_wdata and redirect_pc all 0; capture registers all 0.
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RESTORE_STATUS, REDIRECT.
- Arbitration in IDLE, priority exception > MRET > interrupt.
- Interrupt eligible when all of the following hold: commit_valid, csr_mstatus[3] (MIE) is 1, and (pending & csr_mie_en) is nonzero.
- Interrupt priority: MEI (cause 11), then MSI (cause 3), then MTI (cause 7).
- Capture at the IDLE edge: is_irq, 4-bit code, and saved PC (exc_pc, or irq_pc for interrupts).
- Transitions: exception/interrupt go to SAVE_EPC; MRET goes to RESTORE_STATUS.
- Trap sequence: SAVE_EPC, then SAVE_CAUSE, then SAVE_STATUS, then REDIRECT, then IDLE. MRET sequence: RESTORE_STATUS, then REDIRECT, then IDLE.
- flush pulses in the first cycle after capture, i.e. the first SAVE_EPC or RESTORE_STATUS cycle.
- busy is high in every non-IDLE state. exc_valid, mret_valid and interrupts are ignored while busy.
- Write handshake: in each SAVE/RESTORE state, csr_we is 1 with csr_waddr and csr_wdata stable. The state advances only on a cycle with csr_wready=1. With no backpressure, each write takes 1 cycle.
- SAVE_EPC writes 0x341 with the saved PC and bits[1:0] forced to 0.
- SAVE_CAUSE writes 0x342 with {is_irq, 27'b0, code}.
- SAVE_STATUS writes 0x300 with the live csr_mstatus modified: MPIE(7) = MIE(3), MIE = 0, MPP(12:11) = 2'b11.
- RESTORE_STATUS writes 0x300 modified: MIE = MPIE, MPIE = 1, MPP = 2'b11.
- REDIRECT: redirect_valid = 1 for one cycle.
  - Trap target: base = csr_mtvec with [1:0] cleared. If mtvec[1:0]=01 and is_irq, target = base + 4*code; otherwise target = base.
  - MRET target: csr_mepc with [1:0] cleared.
  - irq_ack = 1 in REDIRECT only when is_irq.
- Latency with csr_wready tied to 1: redirect 4 cycles after capture for a trap, 2 cycles for MRET.
- All arithmetic is modulo 2^XLEN; the vector add wraps silently.
- Reset mid-sequence returns to IDLE immediately. CSR writes already accepted remain; no redirect is issued.

Decomposition:
- Shared package trap_pkg holds:
  - CSR address constants MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
  - mstatus bit indices MIE=3, MPIE=7, MPP_LO=11, MPP_HI=12.
  - Interrupt cause codes 3/7/11.
  - The state enum.
- One combinational sub-module, trap_irq_arb: pending & enable & MIE, priority encode, returns {take, code}.

Test Plan:
- Exception: exc_code=2, exc_pc=0x80000010, mtvec=0x80000100, mstatus=0x8, wready=1.
  -> Writes 0x341=0x80000010, 0x342=0x2, 0x300=0x1880; flush at +1; redirect 0x80000100 at +4.
- Vectored interrupt: mtvec=0x80000101, irq_meip=1, mie_en=3'b100, MIE=1, commit_valid=1, irq_pc=0x80000044.
  -> mcause=0x8000000B; redirect 0x8000012C; irq_ack pulses once.
- MRET: mstatus=0x1880, mepc=0x80000016.
  -> Writes 0x300=0x1888; redirect 0x80000014 at +2.
- Backpressure: csr_wready=0 for 3 cycles in SAVE_CAUSE.
  -> csr_we/waddr/wdata stay at 1/0x342/code; state holds; redirect delayed by exactly 3 cycles.
- Exception and irq_meip asserted in the same cycle -> exception taken with mcause=code.
- Pending interrupt with MIE=0 or commit_valid=0 -> no flush and no write.
- Reset asserted in SAVE_CAUSE -> all outputs 0 the same cycle. A following exception with exc_code=5 completes a normal sequence with mcause=0x5.
